ex_mem_skid_stage: RTL
======================

EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the result payload.
REQ-002 SHALL have parameter ADDR_W, default 5, width of the destination register address.
REQ-003 SHALL have parameter SKID, default 1, where 1 selects a 2-entry skid stage and 0 selects a 1-entry stage with a combinational ready path.
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have flush  input  1  drop all held entries (pipeline kill).
REQ-007 SHALL have in_valid  input  1  EX offers an entry.
REQ-008 SHALL have in_ready  output  1  stage accepts an entry this cycle.
REQ-009 SHALL have result_in  input  DATA_W  EX result.
REQ-010 SHALL have write_reg_en_in  input  1  EX register-write enable.
REQ-011 SHALL have write_reg_addr_in  input  ADDR_W  EX destination register.
REQ-012 SHALL have out_valid  output  1  MEM-side entry present.
REQ-013 SHALL have out_ready  input  1  MEM consumes the entry this cycle.
REQ-014 SHALL have result_out  output  DATA_W, write_reg_en_out  output  1, and write_reg_addr_out  output  ADDR_W, the MEM-side payload.
REQ-015 SHALL have occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 SHALL define an input transfer as in_valid&&in_ready and an output transfer as out_valid&&out_ready, both sampled at the rising edge of clk.
REQ-017 SHALL hold entries in a main register (drives outputs) and, when SKID=1, one skid register, each with its own valid bit.
REQ-018 SHALL, when SKID=1, drive in_ready as the registered value !skid_valid, with no combinational path from out_ready.
REQ-019 SHALL, when SKID=0, drive in_ready as !out_valid||out_ready and never set skid_valid.
REQ-020 SHALL load the main register from the skid register, and clear skid_valid, when skid_valid and an output transfer occur.
REQ-021 SHALL load the main register from the input when an input transfer occurs and the main register is either empty or transferring out with skid empty.
REQ-022 SHALL load the skid register from the input when an input transfer occurs, the main register is valid, and out_ready is low.
REQ-023 SHALL clear out_valid on an output transfer when neither the skid register nor the input supplies a replacement.
REQ-024 SHALL preserve strict FIFO order: no entry is duplicated, dropped (except on flush/rst), or reordered.
REQ-025 SHALL give latency of exactly 1 cycle from input transfer to out_valid when the stage is empty.
REQ-026 SHALL sustain full throughput of 1 entry/cycle when out_ready is held high.
REQ-027 SHALL drive write_reg_en_out as stored_en&&out_valid, so a bubble never requests a register write.
REQ-028 SHALL hold payload registers unchanged when not loaded, and SHALL hold result_out stable while out_valid is high and out_ready is low.
REQ-029 SHALL, on flush, clear both valid bits at the next edge; an input transfer in the same cycle is accepted and discarded; payload registers are unchanged.
REQ-030 SHALL give flush priority over all load rules and rst priority over flush.
REQ-031 SHALL drive occupancy as out_valid+skid_valid; value 2 occurs only with SKID=1.

Reset
REQ-032 SHALL, with rst high at an edge, clear out_valid, skid_valid, all payload registers, write_reg_en_out and occupancy to 0.
REQ-033 SHALL, after reset, hold in_ready at 1 (SKID=1) or at 1 via !out_valid (SKID=0).
REQ-034 SHALL apply reset asserted mid-stream identically, discarding held entries without producing an output transfer.

Verification
REQ-035 SHALL cover pass-through: out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles -> outputs 0x11,0x22,0x33 on the next three cycles, in_ready stays 1.
REQ-036 SHALL cover stall with SKID=1: main holds 0xA, out_ready=0, input 0xB -> occupancy=2, in_ready=0; then out_ready=1 -> output 0xA then 0xB, in_ready returns to 1.
REQ-037 SHALL cover flush: occupancy=2 with flush=1 and in_valid=1 (0xC) -> next cycle out_valid=0, occupancy=0, and 0xC never appears.
REQ-038 SHALL cover bubble write gating: stored en=1 with out_valid=0 after flush -> write_reg_en_out=0.
REQ-039 SHALL cover SKID=0: main full, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 with in_valid -> replacement loaded with no gap.
REQ-040 SHALL cover rst mid-stream: rst for 1 cycle while occupancy=2 -> all outputs 0 and in_ready=1 on the following cycle.

Source files
------------

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with an optional skid entry.
// SKID=1 gives a registered in_ready; SKID=0 gives a single entry.
module ex_mem_skid_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result_in,
    input  logic              write_reg_en_in,
    input  logic [ADDR_W-1:0] write_reg_addr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_out,
    output logic              write_reg_en_out,
    output logic [ADDR_W-1:0] write_reg_addr_out,
    output logic [1:0]        occupancy
);

    localparam bit SKID_EN = (SKID != 0);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              main_en_q, main_en_d;
    logic [ADDR_W-1:0] main_addr_q, main_addr_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_en_q, skid_en_d;
    logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;

    logic in_xfer;
    logic out_xfer;

    assign in_ready = SKID_EN ? !skid_valid_q
                              : (!main_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_en_d    = main_en_q;
        main_addr_d  = main_addr_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_en_d    = skid_en_q;
        skid_addr_d  = skid_addr_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q && out_xfer) begin
            main_data_d  = skid_data_q;
            main_en_d    = skid_en_q;
            main_addr_d  = skid_addr_q;
            skid_valid_d = 1'b0;
        end else if (in_xfer && (!main_valid_q || out_xfer)) begin
            main_valid_d = 1'b1;
            main_data_d  = result_in;
            main_en_d    = write_reg_en_in;
            main_addr_d  = write_reg_addr_in;
        end else if (in_xfer && SKID_EN) begin
            // main is held by a stalled MEM; park the new entry
            skid_valid_d = 1'b1;
            skid_data_d  = result_in;
            skid_en_d    = write_reg_en_in;
            skid_addr_d  = write_reg_addr_in;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_en_q    <= 1'b0;
            main_addr_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_en_q    <= 1'b0;
            skid_addr_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_en_q    <= main_en_d;
            main_addr_q  <= main_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_en_q    <= skid_en_d;
            skid_addr_q  <= skid_addr_d;
        end
    end

    assign out_valid          = main_valid_q;
    assign result_out         = main_data_q;
    assign write_reg_en_out   = main_en_q && main_valid_q;
    assign write_reg_addr_out = main_addr_q;
    assign occupancy          = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
